// File: rtl/branch_resolver_pkg.sv
// Shared definitions for the branch resolver: address width, common constants,
// FSM state encodings, the prediction-queue entry and the next-PC helper.
package branch_resolver_pkg;

    localparam int ADDR_W = 32;

    typedef logic [ADDR_W-1:0] addr_t;

    localparam addr_t ZERO_WORD = '0;
    localparam logic  TRUE      = 1'b1;
    localparam logic  FALSE     = 1'b0;

    // RUN: normal resolution; FLUSH: single recovery cycle after a mispredict
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    // One queued prediction, in fetch order
    typedef struct packed {
        addr_t pc;
        logic  je;
        addr_t jdest;
    } pred_entry_t;

    // Sequential successor is pc+4 with natural 32-bit wrap-around
    function automatic addr_t next_pc(input logic take, input addr_t dest, input addr_t pc);
        return take ? dest : pc + addr_t'(4);
    endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// Fetch/EX/predictor-facing signal bundle of the branch resolver.
// master = pipeline side, slave = resolver side.
interface branch_resolver_if;
    import branch_resolver_pkg::*;

    logic        pred_valid;
    addr_t       pred_pc;
    logic        pred_je;
    addr_t       pred_jdest;
    logic        pq_full;

    logic        ex_valid;
    addr_t       ex_pc;
    logic        ex_is_jmp;
    logic        ex_taken;
    addr_t       ex_dest;

    logic        flush;
    addr_t       redirect_pc;

    addr_t       upd_pc;
    logic        upd_is_jmp;
    addr_t       upd_dest;
    logic        upd_res;

    logic [15:0] br_cnt;
    logic [15:0] miss_cnt;
    logic        err;

    modport master (
        output pred_valid, pred_pc, pred_je, pred_jdest,
        output ex_valid, ex_pc, ex_is_jmp, ex_taken, ex_dest,
        input  pq_full, flush, redirect_pc,
        input  upd_pc, upd_is_jmp, upd_dest, upd_res,
        input  br_cnt, miss_cnt, err
    );

    modport slave (
        input  pred_valid, pred_pc, pred_je, pred_jdest,
        input  ex_valid, ex_pc, ex_is_jmp, ex_taken, ex_dest,
        output pq_full, flush, redirect_pc,
        output upd_pc, upd_is_jmp, upd_dest, upd_res,
        output br_cnt, miss_cnt, err
    );
endinterface

// File: rtl/branch_resolver_pred_queue.sv
// In-order prediction FIFO. Head is read combinationally so EX can compare
// against it in the same cycle it pops. Clear wins over push and pop.
module pred_queue
    import branch_resolver_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic        clear_i,
    input  pred_entry_t wdata_i,
    output logic        full_o,
    output logic        empty_o,
    output pred_entry_t head_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    pred_entry_t   mem [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    assign head_o  = mem[rd_ptr_q];

    // Full is judged before any same-cycle pop, so there is no push-through
    assign do_push = push_i && !full_o && !clear_i;
    assign do_pop  = pop_i && !empty_o && !clear_i;

    // Pointer and occupancy next-state
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
            else if (!do_push && do_pop) count_d = count_q - CNT_ONE;
        end
    end

    // Pointer/occupancy registers; reset discards contents without clearing storage
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage write (no reset, so it can map to distributed RAM)
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata_i;
    end
endmodule

// File: rtl/branch_resolver.sv
// Branch resolver: queues fetch-time predictions, checks them against EX
// results in program order, flushes on mispredict, trains the predictor
// and keeps saturating statistics plus a sticky protocol-error flag.
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    branch_resolver_if.slave bus
);
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    state_e      state_q;
    logic        flush_q, err_q, upd_is_jmp_q, upd_res_q;
    addr_t       redirect_pc_q, upd_pc_q, upd_dest_q;
    logic [15:0] br_cnt_q, br_cnt_d, miss_cnt_q, miss_cnt_d;

    logic        q_full, q_empty, in_run;
    logic        push, pop, empty_err, pc_err, mispredict;
    pred_entry_t head, wdata;
    addr_t       act_next, pred_next;

    assign in_run    = (state_q == ST_RUN);
    assign push      = bus.pred_valid && !q_full && in_run;
    assign pop       = bus.ex_valid && !q_empty && in_run;
    assign empty_err = bus.ex_valid && q_empty && in_run;
    assign pc_err    = pop && (head.pc != bus.ex_pc);

    assign act_next   = next_pc(bus.ex_is_jmp && bus.ex_taken, bus.ex_dest, bus.ex_pc);
    assign pred_next  = next_pc(head.je, head.jdest, head.pc);
    assign mispredict = pop && (act_next != pred_next);

    assign wdata = '{pc: bus.pred_pc, je: bus.pred_je, jdest: bus.pred_jdest};

    pred_queue #(.DEPTH(DEPTH)) u_queue (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .clear_i (mispredict),
        .wdata_i (wdata),
        .full_o  (q_full),
        .empty_o (q_empty),
        .head_o  (head)
    );

    // Saturating statistic increments
    always_comb begin
        br_cnt_d   = br_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (pop && bus.ex_is_jmp && br_cnt_q != CNT_MAX) br_cnt_d   = br_cnt_q + 16'd1;
        if (mispredict && miss_cnt_q != CNT_MAX)         miss_cnt_d = miss_cnt_q + 16'd1;
    end

    // Resolver FSM together with every registered output
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_RUN;
            flush_q       <= FALSE;
            redirect_pc_q <= ZERO_WORD;
            upd_is_jmp_q  <= FALSE;
            upd_res_q     <= FALSE;
            upd_pc_q      <= ZERO_WORD;
            upd_dest_q    <= ZERO_WORD;
            br_cnt_q      <= '0;
            miss_cnt_q    <= '0;
            err_q         <= FALSE;
        end else begin
            flush_q      <= FALSE;
            upd_is_jmp_q <= FALSE;
            case (state_q)
                ST_RUN: begin
                    if (mispredict) begin
                        state_q       <= ST_FLUSH;
                        flush_q       <= TRUE;
                        redirect_pc_q <= act_next;
                    end
                end
                ST_FLUSH: state_q <= ST_RUN;
                default:  state_q <= ST_RUN;
            endcase
            if (pop && bus.ex_is_jmp) begin
                upd_is_jmp_q <= TRUE;
                upd_pc_q     <= bus.ex_pc;
                upd_dest_q   <= bus.ex_dest;
                upd_res_q    <= bus.ex_taken;
            end
            br_cnt_q   <= br_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            if (empty_err || pc_err) err_q <= TRUE;
        end
    end

    assign bus.pq_full     = q_full;
    assign bus.flush       = flush_q;
    assign bus.redirect_pc = redirect_pc_q;
    assign bus.upd_pc      = upd_pc_q;
    assign bus.upd_is_jmp  = upd_is_jmp_q;
    assign bus.upd_dest    = upd_dest_q;
    assign bus.upd_res     = upd_res_q;
    assign bus.br_cnt      = br_cnt_q;
    assign bus.miss_cnt    = miss_cnt_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: a behavioural model computes the
// expected outputs for each driven cycle, queues them, and they are compared
// after the following rising edge.
module tb_branch_resolver;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    branch_resolver_if bus ();

    branch_resolver #(.DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        flush;
        logic [31:0] redir;
        logic        upd_j;
        logic        upd_res;
        logic [31:0] upd_pc;
        logic [31:0] upd_dest;
        logic [15:0] br;
        logic [15:0] miss;
        logic        err;
        logic        full;
    } exp_t;

    typedef struct {
        logic [31:0] pc;
        logic        je;
        logic [31:0] jdest;
    } ent_t;

    exp_t sb[$];
    ent_t m_q[$];

    logic        m_flush, m_upd_j, m_upd_res, m_err;
    logic [31:0] m_redir, m_upd_pc, m_upd_dest;
    logic [15:0] m_br, m_miss;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Model of one clock edge given the inputs currently driven
    task automatic model_edge(input logic pv, input logic [31:0] ppc, input logic pje,
                              input logic [31:0] pjd, input logic ev, input logic [31:0] epc,
                              input logic ej, input logic et, input logic [31:0] ed);
        ent_t        hd;
        logic [31:0] act, prd;
        bit          mis, was_full;
        exp_t        e;
        mis = 0;
        if (!rst) begin
            m_q.delete();
            m_flush = 0; m_upd_j = 0; m_upd_res = 0; m_err = 0;
            m_redir = 0; m_upd_pc = 0; m_upd_dest = 0; m_br = 0; m_miss = 0;
        end else if (m_flush) begin
            m_flush = 0;
            m_upd_j = 0;
        end else begin
            was_full = (m_q.size() == 4);
            m_upd_j  = 0;
            if (ev) begin
                if (m_q.size() == 0) begin
                    m_err = 1;
                end else begin
                    hd = m_q.pop_front();
                    if (hd.pc != epc) m_err = 1;
                    act = (ej && et) ? ed : epc + 32'd4;
                    prd = hd.je ? hd.jdest : hd.pc + 32'd4;
                    if (ej) begin
                        m_upd_j = 1; m_upd_pc = epc; m_upd_dest = ed; m_upd_res = et;
                        if (m_br != 16'hFFFF) m_br = m_br + 16'd1;
                    end
                    if (act != prd) begin
                        mis = 1;
                        m_redir = act;
                        if (m_miss != 16'hFFFF) m_miss = m_miss + 16'd1;
                    end
                end
            end
            if (pv && !was_full && !mis) m_q.push_back('{pc: ppc, je: pje, jdest: pjd});
            if (mis) m_q.delete();
            m_flush = mis;
        end
        e.flush = m_flush; e.redir = m_redir; e.upd_j = m_upd_j; e.upd_res = m_upd_res;
        e.upd_pc = m_upd_pc; e.upd_dest = m_upd_dest; e.br = m_br; e.miss = m_miss;
        e.err = m_err; e.full = (m_q.size() == 4);
        sb.push_back(e);
    endtask

    // Drive one cycle, queue the expectation, then compare after the edge
    task automatic step(input string tag,
                        input logic pv, input logic [31:0] ppc, input logic pje, input logic [31:0] pjd,
                        input logic ev, input logic [31:0] epc, input logic ej, input logic et,
                        input logic [31:0] ed);
        exp_t e;
        bus.pred_valid = pv; bus.pred_pc = ppc; bus.pred_je = pje; bus.pred_jdest = pjd;
        bus.ex_valid = ev; bus.ex_pc = epc; bus.ex_is_jmp = ej; bus.ex_taken = et; bus.ex_dest = ed;
        model_edge(pv, ppc, pje, pjd, ev, epc, ej, et, ed);
        @(posedge clk);
        #1;
        bus.pred_valid = 1'b0;
        bus.ex_valid   = 1'b0;
        if (sb.size() == 0) begin
            check_eq({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check_eq({tag, ".flush"},       32'(bus.flush),       32'(e.flush));
            check_eq({tag, ".redirect_pc"}, bus.redirect_pc,      e.redir);
            check_eq({tag, ".upd_is_jmp"},  32'(bus.upd_is_jmp),  32'(e.upd_j));
            check_eq({tag, ".upd_res"},     32'(bus.upd_res),     32'(e.upd_res));
            check_eq({tag, ".upd_pc"},      bus.upd_pc,           e.upd_pc);
            check_eq({tag, ".upd_dest"},    bus.upd_dest,         e.upd_dest);
            check_eq({tag, ".br_cnt"},      32'(bus.br_cnt),      32'(e.br));
            check_eq({tag, ".miss_cnt"},    32'(bus.miss_cnt),    32'(e.miss));
            check_eq({tag, ".err"},         32'(bus.err),         32'(e.err));
            check_eq({tag, ".pq_full"},     32'(bus.pq_full),     32'(e.full));
            $display("[TB] %-14s flush=%0d redir=%h upd_j=%0d res=%0d br=%0d miss=%0d err=%0d full=%0d",
                     tag, bus.flush, bus.redirect_pc, bus.upd_is_jmp, bus.upd_res,
                     bus.br_cnt, bus.miss_cnt, bus.err, bus.pq_full);
        end
    endtask

    task automatic push_only(input string tag, input logic [31:0] pc, input logic je, input logic [31:0] jd);
        step(tag, 1'b1, pc, je, jd, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic pop_only(input string tag, input logic [31:0] epc, input logic ej, input logic et,
                            input logic [31:0] ed);
        step(tag, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, epc, ej, et, ed);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        idle(tag);
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.pred_valid = 1'b0; bus.pred_pc = '0; bus.pred_je = 1'b0; bus.pred_jdest = '0;
        bus.ex_valid = 1'b0; bus.ex_pc = '0; bus.ex_is_jmp = 1'b0; bus.ex_taken = 1'b0; bus.ex_dest = '0;

        do_reset("reset");

        // Sequential instruction predicted correctly
        push_only("seq_push", 32'h100, 1'b0, 32'h0);
        pop_only ("seq_pop",  32'h100, 1'b0, 1'b0, 32'h0);

        // Taken jump predicted correctly: trains predictor, no flush
        push_only("jmp_push", 32'h200, 1'b1, 32'h300);
        pop_only ("jmp_pop",  32'h200, 1'b1, 1'b1, 32'h300);
        idle     ("jmp_after");

        // Predicted not-taken, actually taken -> flush to 0x80
        push_only("mis1_push", 32'h400, 1'b0, 32'h0);
        pop_only ("mis1_pop",  32'h400, 1'b1, 1'b1, 32'h80);
        // Inputs during FLUSH must be ignored (no push, no empty-queue error)
        step     ("mis1_flush", 1'b1, 32'h900, 1'b0, 32'h0, 1'b1, 32'h900, 1'b0, 1'b0, 32'h0);

        // Predicted taken, actually not taken -> redirect to pc+4
        push_only("mis2_push", 32'h500, 1'b1, 32'h600);
        pop_only ("mis2_pop",  32'h500, 1'b1, 1'b0, 32'h600);
        idle     ("mis2_flush");

        // Sequential PC wraps past the top of the address space on both sides
        push_only("wrap_push", 32'hFFFF_FFFC, 1'b0, 32'h0);
        pop_only ("wrap_pop",  32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);

        // Fill, overfill, then drain in order; push while full+pop is dropped
        for (int i = 0; i < 4; i++) push_only($sformatf("fill%0d", i), 32'h1000 + 32'(i) * 32'h10, 1'b0, 32'h0);
        push_only("fill_extra", 32'h2000, 1'b0, 32'h0);
        step     ("drain0_push", 1'b1, 32'h3000, 1'b0, 32'h0, 1'b1, 32'h1000, 1'b0, 1'b0, 32'h0);
        for (int i = 1; i < 4; i++) pop_only($sformatf("drain%0d", i), 32'h1000 + 32'(i) * 32'h10, 1'b0, 1'b0, 32'h0);
        pop_only ("empty_pop", 32'h3000, 1'b0, 1'b0, 32'h0);
        idle     ("err_sticky");

        // PC mismatch on pop with 3 queued, then reset during the FLUSH cycle
        do_reset("reset2");
        for (int i = 0; i < 3; i++) push_only($sformatf("q3_%0d", i), 32'h700 + 32'(i) * 32'h10, 1'b0, 32'h0);
        pop_only ("pcmis_pop", 32'h704, 1'b0, 1'b0, 32'h0);
        do_reset("rst_in_flush");
        idle     ("post_rst");

        // Reset with a non-empty queue discards the entries
        for (int i = 0; i < 3; i++) push_only($sformatf("q3b_%0d", i), 32'hA00 + 32'(i) * 32'h10, 1'b0, 32'h0);
        do_reset("rst_nonempty");
        pop_only ("pop_after_rst", 32'hA00, 1'b0, 1'b0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
